// File: rtl/alu_pkg.sv
//==== alu_pkg | rev 1.0 ====================================================
//  Op codes, funct codes, FSM states and the ALUOp/funct decoder shared by the execute stage.
`default_nettype none

package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_MUL = 4'b1000;
  localparam logic [3:0] ALU_DIV = 4'b1001;
  localparam logic [3:0] ALU_XOR = 4'b1010;
  localparam logic [3:0] ALU_SLL = 4'b1100;
  localparam logic [3:0] ALU_SRL = 4'b1101;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;
  localparam logic [5:0] F_MUL = 6'b110000;
  localparam logic [5:0] F_DIV = 6'b110001;
  localparam logic [5:0] F_XOR = 6'b100110;
  localparam logic [5:0] F_SLL = 6'b000000;
  localparam logic [5:0] F_SRL = 6'b000010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  typedef struct packed {
    logic [3:0] op;
    logic       illegal;
  } dec_t;

  function automatic dec_t alu_decode(input logic [1:0] alu_op, input logic [5:0] funct,
                                      input logic div_en);
    dec_t d;
    d.op      = ALU_ADD;
    d.illegal = 1'b0;
    case (alu_op)
      2'b00: d.op = ALU_ADD;
      2'b01: d.op = ALU_SUB;
      2'b10: begin
        case (funct)
          F_ADD:   d.op = ALU_ADD;
          F_SUB:   d.op = ALU_SUB;
          F_AND:   d.op = ALU_AND;
          F_OR:    d.op = ALU_OR;
          F_SLT:   d.op = ALU_SLT;
          F_MUL:   d.op = ALU_MUL;
          F_XOR:   d.op = ALU_XOR;
          F_SLL:   d.op = ALU_SLL;
          F_SRL:   d.op = ALU_SRL;
          F_DIV: begin
            if (div_en) d.op = ALU_DIV;
            else        d.illegal = 1'b1;
          end
          default: d.illegal = 1'b1;
        endcase
      end
      default: d.illegal = 1'b1;
    endcase
    return d;
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_iter_muldiv.sv
//==== alu_iter_muldiv | rev 1.0 ============================================
//  WIDTH-step shift-add multiplier / restoring divider; divider only when ALU_DIV_EN is defined.
`default_nettype none

module alu_iter_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             last,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);

  localparam int CNT_W = $clog2(WIDTH);

  logic             busy;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH:0]   mul_sum;

  // lo/hi are the values after the step currently in progress
  assign mul_sum = {1'b0, acc} + (quo[0] ? {1'b0, dvs} : '0);
  assign last    = busy && (cnt == '0);

`ifdef ALU_DIV_EN
  logic           div_mode;
  logic [WIDTH:0] div_shift;
  logic [WIDTH:0] div_diff;

  assign div_shift = {acc, quo[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, dvs};

  always_comb begin
    if (div_mode) begin
      hi = div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
      lo = {quo[WIDTH-2:0], ~div_diff[WIDTH]};
    end else begin
      hi = mul_sum[WIDTH:1];
      lo = {mul_sum[0], quo[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        div_mode <= 1'b0;
    else if (start) div_mode <= is_div;
  end
`else
  logic unused_is_div;
  assign unused_is_div = is_div;
  assign hi = mul_sum[WIDTH:1];
  assign lo = {mul_sum[0], quo[WIDTH-1:1]};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= 1'b0;
      cnt  <= '0;
      acc  <= '0;
      quo  <= '0;
      dvs  <= '0;
    end else if (start) begin
      busy <= 1'b1;
      cnt  <= CNT_W'(WIDTH - 1);
      acc  <= '0;
      quo  <= a;
      dvs  <= b;
    end else if (busy) begin
      acc <= hi;
      quo <= lo;
      if (cnt == '0) busy <= 1'b0;
      else           cnt  <= cnt - 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/alu_exec_unit.sv
//==== alu_exec_unit | rev 1.0 ==============================================
//  ALU decode + execute stage with valid/ready handshake; define ALU_DIV_EN to build the divider.
`default_nettype none

module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         alu_op,
  input  logic [5:0]         funct,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   result,
  output logic [WIDTH-1:0]   hi,
  output logic               zero,
  output logic               mem_op,
  output logic               illegal,
  output logic               div_zero
);

`ifdef ALU_DIV_EN
  localparam logic DIV_EN = 1'b1;
`else
  localparam logic DIV_EN = 1'b0;
`endif

  state_t           state, state_nxt;
  dec_t             dec;
  logic             accept, b_zero, is_mul, is_div, eng_start, eng_last, sc_dz;
  logic [WIDTH-1:0] sc_lo, sc_hi, eng_lo, eng_hi;

  assign dec       = alu_decode(alu_op, funct, DIV_EN);
  assign in_ready  = (state == ST_IDLE) || (state == ST_DONE && out_ready);
  assign out_valid = (state == ST_DONE);
  assign accept    = in_valid && in_ready;
  assign b_zero    = (op_b == '0);
  assign is_mul    = !dec.illegal && (dec.op == ALU_MUL);
  assign is_div    = !dec.illegal && (dec.op == ALU_DIV);
  // Divide by zero never starts the engine; its fixed answer comes from the single-cycle path
  assign eng_start = accept && (is_mul || (is_div && !b_zero));

  alu_iter_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk    (clk),
    .rst    (rst),
    .start  (eng_start),
    .is_div (is_div),
    .a      (op_a),
    .b      (op_b),
    .last   (eng_last),
    .lo     (eng_lo),
    .hi     (eng_hi)
  );

  always_comb begin
    sc_lo = '0;
    sc_hi = '0;
    sc_dz = 1'b0;
    if (!dec.illegal) begin
      case (dec.op)
        ALU_ADD: sc_lo = op_a + op_b;
        ALU_SUB: sc_lo = op_a - op_b;
        ALU_AND: sc_lo = op_a & op_b;
        ALU_OR:  sc_lo = op_a | op_b;
        ALU_XOR: sc_lo = op_a ^ op_b;
        ALU_SLT: sc_lo = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
        ALU_SLL: sc_lo = op_b << shamt;
        ALU_SRL: sc_lo = op_b >> shamt;
`ifdef ALU_DIV_EN
        ALU_DIV: begin
          if (b_zero) begin
            sc_lo = '1;
            sc_hi = op_a;
            sc_dz = 1'b1;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (accept) begin
          if (eng_start) state_nxt = is_mul ? ST_MUL : ST_DIV;
          else           state_nxt = ST_DONE;
        end else if (state == ST_DONE && out_ready) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_MUL, ST_DIV: if (eng_last) state_nxt = ST_DONE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      result   <= '0;
      hi       <= '0;
      zero     <= 1'b0;
      mem_op   <= 1'b0;
      illegal  <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        result   <= sc_lo;
        hi       <= sc_hi;
        zero     <= (sc_lo == '0);
        mem_op   <= (alu_op == 2'b00);
        illegal  <= dec.illegal;
        div_zero <= sc_dz;
      end else if (eng_last) begin
        result <= eng_lo;
        hi     <= eng_hi;
        zero   <= (eng_lo == '0);
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_exec_unit.sv
//==== tb_alu_exec_unit | rev 1.0 ===========================================
//  Self-checking bench for alu_exec_unit (WIDTH=32); follows ALU_DIV_EN like the design.
`default_nettype none

module tb_alu_exec_unit;

  localparam int W = 32;
`ifdef ALU_DIV_EN
  localparam bit DIV_ON = 1'b1;
`else
  localparam bit DIV_ON = 1'b0;
`endif

  logic          clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
  logic [1:0]    alu_op = '0;
  logic [5:0]    funct = '0;
  logic [4:0]    shamt = '0;
  logic [W-1:0]  op_a = '0, op_b = '0;
  logic          in_ready, out_valid, zero, mem_op, illegal, div_zero;
  logic [W-1:0]  result, hi;

  alu_exec_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .funct(funct), .shamt(shamt), .op_a(op_a), .op_b(op_b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .hi(hi),
    .zero(zero), .mem_op(mem_op), .illegal(illegal), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0, bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Expected outcome of one accepted operation, due = cycle in which out_valid must appear
  typedef struct {
    logic [31:0] res;
    logic [31:0] hi;
    logic [3:0]  fl;   // {zero, mem_op, illegal, div_zero}
    int          due;
  } exp_t;

  function automatic exp_t model(input logic [1:0] ao, input logic [5:0] fn, input logic [4:0] sh,
                                 input logic [31:0] a, input logic [31:0] b, input int now);
    exp_t e;
    logic [63:0] p;
    logic il, dz;
    int lat;
    e.res = '0; e.hi = '0; il = 1'b0; dz = 1'b0; lat = 1;
    if (ao == 2'b00)      e.res = a + b;
    else if (ao == 2'b01) e.res = a - b;
    else if (ao == 2'b10) begin
      case (fn)
        6'b100000: e.res = a + b;
        6'b100010: e.res = a - b;
        6'b100100: e.res = a & b;
        6'b100101: e.res = a | b;
        6'b100110: e.res = a ^ b;
        6'b101010: e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        6'b000000: e.res = b << sh;
        6'b000010: e.res = b >> sh;
        6'b110000: begin
          p = 64'(a) * 64'(b);
          e.res = p[31:0]; e.hi = p[63:32]; lat = W + 1;
        end
        6'b110001: begin
          if (!DIV_ON)      il = 1'b1;
          else if (b == 0) begin e.res = '1; e.hi = a; dz = 1'b1; end
          else begin e.res = a / b; e.hi = a % b; lat = W + 1; end
        end
        default: il = 1'b1;
      endcase
    end else il = 1'b1;
    e.fl  = {(e.res == 0), (ao == 2'b00), il, dz};
    e.due = now + lat;
    return e;
  endfunction

  exp_t q[$];

  always @(negedge clk) begin
    logic ev, er;
    if (rst) begin
      q.delete();
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_lo_hi", {result, hi}, 64'd0);
      chk("rst_flags", 64'({zero, mem_op, illegal, div_zero}), 64'd0);
    end else begin
      ev = (q.size() != 0) && (cyc >= q[0].due);
      er = (q.size() == 0) || (ev && out_ready);
      chk("mdl_out_valid", 64'(out_valid), 64'(ev));
      chk("mdl_in_ready", 64'(in_ready), 64'(er));
      if (ev) begin
        chk("mdl_result", 64'(result), 64'(q[0].res));
        chk("mdl_hi", 64'(hi), 64'(q[0].hi));
        chk("mdl_flags", 64'({zero, mem_op, illegal, div_zero}), 64'(q[0].fl));
      end
      if (ev && out_ready) void'(q.pop_front());
      if (in_valid && er) q.push_back(model(alu_op, funct, shamt, op_a, op_b, cyc));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1);
  end

  // Offer one op, wait (bounded) for acceptance, then scramble operands to prove latching
  task automatic issue(input logic [1:0] ao, input logic [5:0] fn, input logic [4:0] sh,
                       input logic [31:0] a, input logic [31:0] b);
    int n;
    n = 0;
    alu_op = ao; funct = fn; shamt = sh; op_a = a; op_b = b; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    if (!in_ready) chk("issue_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; op_a = $urandom; op_b = $urandom;
  endtask

  task automatic run(input string nm, input logic [1:0] ao, input logic [5:0] fn, input logic [4:0] sh,
                     input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] er, input logic [31:0] eh, input int el, input logic [3:0] ef);
    int k, irb;
    k = 0; irb = 0;
    issue(ao, fn, sh, a, b);
    do begin
      @(negedge clk); k++;
      if (!out_valid && in_ready) irb++;
    end while (!out_valid && k < 100);
    chk({nm, " latency"}, 64'(k), 64'(el));
    chk({nm, " result"}, 64'(result), 64'(er));
    chk({nm, " hi"}, 64'(hi), 64'(eh));
    chk({nm, " flags"}, 64'({zero, mem_op, illegal, div_zero}), 64'(ef));
    chk({nm, " busy_in_ready"}, 64'(irb), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_result", 64'(result), 64'd0);
    chk("reset_flags", 64'({out_valid, zero, mem_op, illegal, div_zero}), 64'd0);
    rst = 1'b0;
    #1 chk("reset_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;

    run("sub",      2'b10, 6'b100010, 5'd0,  32'd5,          32'd7,          32'hFFFFFFFE, 32'd0, 1,  4'b0000);
    run("mul",      2'b10, 6'b110000, 5'd0,  32'hFFFFFFFF,   32'd2,          32'hFFFFFFFE, 32'd1, 33, 4'b0000);
`ifdef ALU_DIV_EN
    run("div",      2'b10, 6'b110001, 5'd0,  32'd100,        32'd7,          32'd14,       32'd2,   33, 4'b0000);
    run("div_zero", 2'b10, 6'b110001, 5'd0,  32'd100,        32'd0,          32'hFFFFFFFF, 32'd100, 1,  4'b0001);
`else
    run("div_off",  2'b10, 6'b110001, 5'd0,  32'd100,        32'd7,          32'd0,        32'd0, 1,  4'b1010);
`endif
    run("slt",      2'b10, 6'b101010, 5'd0,  32'h80000000,   32'd1,          32'd1,        32'd0, 1,  4'b0000);
    run("op11",     2'b11, 6'b100000, 5'd0,  32'd3,          32'd4,          32'd0,        32'd0, 1,  4'b1010);
    run("bad_fn",   2'b10, 6'b111111, 5'd0,  32'd3,          32'd4,          32'd0,        32'd0, 1,  4'b1010);
    run("sll",      2'b10, 6'b000000, 5'd4,  32'd9,          32'd1,          32'd16,       32'd0, 1,  4'b0000);
    run("srl",      2'b10, 6'b000010, 5'd31, 32'd9,          32'h80000000,   32'd1,        32'd0, 1,  4'b0000);
    run("and",      2'b10, 6'b100100, 5'd0,  32'hF0F0F0F0,   32'h0FF00FF0,   32'h00F000F0, 32'd0, 1,  4'b0000);
    run("or",       2'b10, 6'b100101, 5'd0,  32'h0F0F0000,   32'h00000F0F,   32'h0F0F0F0F, 32'd0, 1,  4'b0000);
    run("xor",      2'b10, 6'b100110, 5'd0,  32'hFFFF0000,   32'hFF00FF00,   32'h00FFFF00, 32'd0, 1,  4'b0000);
    run("add_wrap", 2'b00, 6'b000000, 5'd0,  32'hFFFFFFFF,   32'd1,          32'd0,        32'd0, 1,  4'b1100);
    run("beq_sub",  2'b01, 6'b000000, 5'd0,  32'd42,         32'd42,         32'd0,        32'd0, 1,  4'b1000);
    run("mul_big",  2'b10, 6'b110000, 5'd0,  32'h00010001,   32'h00020003,   32'h00050003, 32'd2, 33, 4'b0000);

    // Four back-to-back memory adds, one result per cycle
    for (int i = 0; i < 4; i++) begin
      alu_op = 2'b00; funct = 6'b0; op_a = 32'(i + 1); op_b = 32'(10 * (i + 1)); in_valid = 1'b1;
      @(negedge clk);
      chk("stream_in_ready", 64'(in_ready), 64'd1);
      if (i > 0) begin
        chk("stream_valid", 64'(out_valid), 64'd1);
        chk("stream_result", 64'(result), 64'(11 * i));
        chk("stream_mem_op", 64'(mem_op), 64'd1);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("stream_valid", 64'(out_valid), 64'd1);
    chk("stream_result", 64'(result), 64'd44);
    @(posedge clk); #1;

    // Back-pressure: result holds, new op waits until out_ready returns
    out_ready = 1'b0;
    issue(2'b00, 6'b0, 5'd0, 32'd1, 32'd2);
    alu_op = 2'b00; op_a = 32'd10; op_b = 32'd20; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_valid", 64'(out_valid), 64'd1);
      chk("stall_result", 64'(result), 64'd3);
      chk("stall_in_ready", 64'(in_ready), 64'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("release_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("release_result", 64'(result), 64'd30);
    @(posedge clk); #1;

    // Reset 10 cycles into a multiply
    issue(2'b10, 6'b110000, 5'd0, 32'd3, 32'd5);
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midrst_valid", 64'(out_valid), 64'd0);
    chk("midrst_lo_hi", {result, hi}, 64'd0);
    chk("midrst_flags", 64'({zero, mem_op, illegal, div_zero}), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1 chk("midrst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    run("post_rst_add", 2'b00, 6'b0, 5'd0, 32'd7, 32'd8, 32'd15, 32'd0, 1, 4'b0100);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
